output_buffer: RTL and testbench



---
 rtl/output_buffer.sv | 141 ++++++++++++++
 tb/tb_output_buffer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/output_buffer.sv
// Row output buffer: captures a full pixel row on SET_BUFFER and streams it
// out OUTPUT_BUS_WIDTH pixels per beat, with a forwarded strobe OUTPUT_CLK
// whose rising edge sits in the middle of each stable data window.
// Optional build macro: OUTPUT_BUFFER_DONE_EN adds a one-cycle DONE pulse
// when a row finishes streaming normally.
module output_buffer #(
    parameter int PIXEL_ARRAY_WIDTH = 8,
    parameter int PIXEL_BITS        = 8,
    parameter int OUTPUT_BUS_WIDTH  = 2
) (
    input  logic                                         CLK,
    input  logic                                         RESET,
    input  logic                                         SET_BUFFER,
    input  logic [PIXEL_ARRAY_WIDTH-1:0][PIXEL_BITS-1:0] DATA_IN,
    output logic                                         OUTPUT_CLK,
    output logic [OUTPUT_BUS_WIDTH*PIXEL_BITS-1:0]       DATA_OUT
`ifdef OUTPUT_BUFFER_DONE_EN
    ,
    output logic                                         DONE
`endif
);

    localparam int NBEATS    = PIXEL_ARRAY_WIDTH / OUTPUT_BUS_WIDTH;
    localparam int BEAT_BITS = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int WORD_BITS = OUTPUT_BUS_WIDTH * PIXEL_BITS;
    localparam int ROW_BITS  = PIXEL_ARRAY_WIDTH * PIXEL_BITS;
    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(NBEATS - 1);

    // A row must split into a whole number of beats.
    if (NBEATS * OUTPUT_BUS_WIDTH != PIXEL_ARRAY_WIDTH) begin : g_width_check
        $error("PIXEL_ARRAY_WIDTH must be a multiple of OUTPUT_BUS_WIDTH");
    end

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                 state_reg, state_next;
    logic [BEAT_BITS-1:0]   beat_reg, beat_next, beat_inc;
    logic                   phase_reg, phase_next;
    logic                   oclk_next;
    logic [WORD_BITS-1:0]   dout_next;
    logic [ROW_BITS-1:0]    row_reg;
    logic [ROW_BITS-1:0]    data_in_flat;
    logic [WORD_BITS-1:0]   beat_words [NBEATS];
`ifdef OUTPUT_BUFFER_DONE_EN
    logic                   done_next;
`endif

    assign data_in_flat = DATA_IN;
    assign beat_inc     = beat_reg + BEAT_BITS'(1);

    // Slice the captured row into beat-sized words, lowest pixels first.
    for (genvar gi = 0; gi < NBEATS; gi++) begin : g_beat_words
        assign beat_words[gi] = row_reg[gi*WORD_BITS +: WORD_BITS];
    end

    // Row capture; contents are don't-care until the first load.
    always_ff @(posedge CLK) begin
        if (SET_BUFFER) begin
            row_reg <= data_in_flat;
        end
    end

    // Next-state and output decode. A load wins over everything but reset,
    // so it also serves as the abort/restart path during SEND.
    always_comb begin
        state_next = state_reg;
        beat_next  = beat_reg;
        phase_next = phase_reg;
        oclk_next  = OUTPUT_CLK;
        dout_next  = DATA_OUT;
`ifdef OUTPUT_BUFFER_DONE_EN
        done_next  = 1'b0;
`endif
        if (SET_BUFFER) begin
            state_next = SEND;
            beat_next  = '0;
            phase_next = 1'b1;
            oclk_next  = 1'b0;
            dout_next  = data_in_flat[WORD_BITS-1:0];
        end else begin
            case (state_reg)
                IDLE: begin
                    oclk_next = 1'b0;
                    dout_next = '0;
                end
                SEND: begin
                    if (phase_reg) begin
                        // Data has been set up for a full cycle: raise strobe.
                        oclk_next  = 1'b1;
                        phase_next = 1'b0;
                    end else if (beat_reg != LAST_BEAT) begin
                        // Strobe falls and next beat's data launches together.
                        beat_next  = beat_inc;
                        dout_next  = beat_words[beat_inc];
                        oclk_next  = 1'b0;
                        phase_next = 1'b1;
                    end else begin
                        oclk_next  = 1'b0;
                        dout_next  = '0;
                        state_next = IDLE;
`ifdef OUTPUT_BUFFER_DONE_EN
                        done_next  = 1'b1;
`endif
                    end
                end
                default: begin
                    state_next = IDLE;
                    oclk_next  = 1'b0;
                    dout_next  = '0;
                end
            endcase
        end
    end

    // State and registered outputs; reset overrides any pending load.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg  <= IDLE;
            beat_reg   <= '0;
            phase_reg  <= 1'b0;
            OUTPUT_CLK <= 1'b0;
            DATA_OUT   <= '0;
`ifdef OUTPUT_BUFFER_DONE_EN
            DONE       <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            beat_reg   <= beat_next;
            phase_reg  <= phase_next;
            OUTPUT_CLK <= oclk_next;
            DATA_OUT   <= dout_next;
`ifdef OUTPUT_BUFFER_DONE_EN
            DONE       <= done_next;
`endif
        end
    end

endmodule

// File: tb/tb_output_buffer.sv
// Scoreboard bench for output_buffer: stimulus pushes the beats a row should
// produce (with the clock edge each strobe rise is due) into a queue; the
// monitor pops on every OUTPUT_CLK rise and checks level, timing and data.
module tb_output_buffer;

    localparam int PAW    = 8;
    localparam int PB     = 8;
    localparam int OBW    = 2;
    localparam int NBEATS = PAW / OBW;
    localparam int WBITS  = OBW * PB;

    typedef logic [PAW-1:0][PB-1:0] row_t;
    typedef struct {
        logic [WBITS-1:0] data;
        int               cyc;
    } beat_t;

    logic             CLK = 1'b0;
    logic             RESET = 1'b1;
    logic             SET_BUFFER = 1'b0;
    row_t             DATA_IN = '0;
    logic             OUTPUT_CLK;
    logic [WBITS-1:0] DATA_OUT;
`ifdef OUTPUT_BUFFER_DONE_EN
    logic             DONE;
`endif

    output_buffer #(
        .PIXEL_ARRAY_WIDTH(PAW),
        .PIXEL_BITS(PB),
        .OUTPUT_BUS_WIDTH(OBW)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .SET_BUFFER(SET_BUFFER),
        .DATA_IN(DATA_IN),
        .OUTPUT_CLK(OUTPUT_CLK),
        .DATA_OUT(DATA_OUT)
`ifdef OUTPUT_BUFFER_DONE_EN
        ,
        .DONE(DONE)
`endif
    );

    always #5 CLK = ~CLK;

    int    cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    beat_t q[$];
    int    end_cycle = 0;
    bit    armed = 0;
    bit    active = 0;
    int    checks = 0;
    int    passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s at edge %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    endtask

    // Reference model: a load at edge L yields beat j on the rise at L+1+2j
    // and returns to idle at L+2*NBEATS; any load or reset drops pending beats.
    function automatic void model_load(input int l, input row_t row);
        beat_t b;
        q.delete();
        for (int j = 0; j < NBEATS; j++) begin
            b.cyc = l + 1 + 2 * j;
            for (int p = 0; p < OBW; p++) b.data[p*PB +: PB] = row[j*OBW + p];
            q.push_back(b);
        end
        end_cycle = l + 2 * NBEATS;
        armed = 1;
    endfunction

    function automatic void model_reset(input int r);
        q.delete();
        end_cycle = r;
        armed = 0;
    endfunction

    function automatic row_t rand_row();
        row_t r;
        for (int i = 0; i < PAW; i++) r[i] = PB'($urandom);
        return r;
    endfunction

    // One cycle of stimulus, applied on the falling edge for the next rise.
    task automatic step(input logic set, input logic rst, input row_t row);
        @(negedge CLK);
        SET_BUFFER = set;
        RESET = rst;
        DATA_IN = row;
        if (rst) begin
            model_reset(cyc + 1);
            active = 1;
        end else if (set) begin
            model_load(cyc + 1, row);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, rand_row());
    endtask

    // Monitor: checks outputs 1 time unit after every active edge.
    logic             prev_oclk = 1'b0;
    logic [WBITS-1:0] prev_dout = '0;
    always @(posedge CLK) begin
        #1;
        if (active) begin
            automatic int    n = cyc;
            automatic bit    exp_rise = (q.size() > 0) && (q[0].cyc == n);
            automatic beat_t b;
            chk("output_clk", 64'(OUTPUT_CLK), 64'(exp_rise));
            if (OUTPUT_CLK === 1'b1 && prev_oclk !== 1'b1 && q.size() > 0) begin
                b = q.pop_front();
                chk("rise_edge", 64'(n), 64'(b.cyc));
                chk("beat_data", 64'(DATA_OUT), 64'(b.data));
                chk("setup_stable", 64'(DATA_OUT), 64'(prev_dout));
            end else begin
                while (q.size() > 0 && q[0].cyc <= n) void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].cyc == n + 1)
                chk("setup_data", 64'(DATA_OUT), 64'(q[0].data));
            if (q.size() == 0 && n >= end_cycle)
                chk("idle_data", 64'(DATA_OUT), 64'(0));
`ifdef OUTPUT_BUFFER_DONE_EN
            chk("done", 64'(DONE), 64'(armed && n == end_cycle));
`endif
        end
        prev_oclk = OUTPUT_CLK;
        prev_dout = DATA_OUT;
    end

    initial begin
        row_t ramp, high;
        for (int i = 0; i < PAW; i++) begin
            ramp[i] = PB'(i);
            high[i] = PB'(8'hF0 + i);
        end

        // Reset, then a long quiet stretch with no load.
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b1, '0);
        idle(50);

        // Basic stream of the ramp row.
        step(1'b1, 1'b0, ramp);
        idle(12);

        // Abort after two beats with the 0xF0+i row.
        step(1'b1, 1'b0, ramp);
        idle(4);
        step(1'b1, 1'b0, high);
        idle(12);

        // Reset during beat 1, then a normal load.
        step(1'b1, 1'b0, ramp);
        idle(2);
        step(1'b0, 1'b1, ramp);
        idle(6);
        step(1'b1, 1'b0, rand_row());
        idle(12);

        // SET_BUFFER held for several cycles with changing rows.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, rand_row());
        idle(12);

        // Random mix of loads, holds, aborts and resets.
        for (int it = 0; it < 150; it++) begin
            automatic int k = $urandom_range(0, 9);
            if (k < 6) begin
                step(1'b1, 1'b0, rand_row());
                idle($urandom_range(0, 10));
            end else if (k == 6) begin
                for (int i = 0; i < $urandom_range(2, 4); i++) step(1'b1, 1'b0, rand_row());
            end else if (k == 7) begin
                step(1'b0, 1'b1, rand_row());
            end else begin
                idle(2 * NBEATS + 4);
            end
        end

        idle(2 * NBEATS + 6);
        chk("queue_drained", 64'(q.size()), 64'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
